dnn_tile_sequencer: RTL and testbench

DNN_TILE_SEQUENCER -- requirements
Module: dnn_tile_sequencer

---
 rtl/dnn_tile_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_dnn_tile_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_tile_sequencer.sv
// Control sequencer for one DNN PE-array tile: streams weights and ifmap rows into the
// register files, launches compute passes, and unloads the ofmap rows per output tile.
module dnn_tile_sequencer #(
  parameter int unsigned ROWS    = 5,
  parameter int unsigned COLS    = 5,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_num_tiles,
  input  logic [CNT_W-1:0] cfg_num_ch,
  input  logic             cfg_wt_reload,
  input  logic             wt_valid,
  output logic             wt_ready,
  output logic [COLS-1:0]  wt_col_we,
  input  logic             if_valid,
  output logic             if_ready,
  output logic [ROWS-1:0]  if_row_we,
  output logic             pe_start,
  output logic             pe_acc,
  input  logic             pe_done,
  output logic             of_valid,
  input  logic             of_ready,
  output logic [ROWS-1:0]  of_row_sel,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLdWt, StLdIf, StExec, StUnldOf, StFin, StErr
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tiles_q, tiles_d;
  logic [CNT_W-1:0] ch_q, ch_d;
  logic             reload_q, reload_d;
  logic [CNT_W-1:0] tile_idx_q, tile_idx_d;
  logic [CNT_W-1:0] ch_idx_q, ch_idx_d;
  logic [CW-1:0]    col_idx_q, col_idx_d;
  logic [RW-1:0]    row_idx_q, row_idx_d;
  logic [TW-1:0]    exec_cnt_q, exec_cnt_d;

  logic             wt_ready_c, if_ready_c, pe_start_c, pe_acc_c, of_valid_c;
  logic             busy_c, done_c, err_c;
  logic [COLS-1:0]  wt_col_we_c;
  logic [ROWS-1:0]  if_row_we_c, of_row_sel_c;

  // Widened by one bit so the +1 comparisons cannot wrap at CNT_W.
  logic [CNT_W:0]   ch_next, tile_next;
  assign ch_next   = {1'b0, ch_idx_q} + 1'b1;
  assign tile_next = {1'b0, tile_idx_q} + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tiles_q    <= '0;
      ch_q       <= '0;
      reload_q   <= 1'b0;
      tile_idx_q <= '0;
      ch_idx_q   <= '0;
      col_idx_q  <= '0;
      row_idx_q  <= '0;
      exec_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tiles_q    <= tiles_d;
      ch_q       <= ch_d;
      reload_q   <= reload_d;
      tile_idx_q <= tile_idx_d;
      ch_idx_q   <= ch_idx_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tiles_d      = tiles_q;
    ch_d         = ch_q;
    reload_d     = reload_q;
    tile_idx_d   = tile_idx_q;
    ch_idx_d     = ch_idx_q;
    col_idx_d    = col_idx_q;
    row_idx_d    = row_idx_q;
    exec_cnt_d   = exec_cnt_q;
    wt_ready_c   = 1'b0;
    if_ready_c   = 1'b0;
    pe_start_c   = 1'b0;
    pe_acc_c     = 1'b0;
    of_valid_c   = 1'b0;
    done_c       = 1'b0;
    err_c        = 1'b0;
    wt_col_we_c  = '0;
    if_row_we_c  = '0;
    of_row_sel_c = '0;
    busy_c       = (state_q != StIdle) && (state_q != StErr);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tiles_d    = cfg_num_tiles;
          ch_d       = cfg_num_ch;
          reload_d   = cfg_wt_reload;
          tile_idx_d = '0;
          ch_idx_d   = '0;
          col_idx_d  = '0;
          row_idx_d  = '0;
          exec_cnt_d = '0;
          state_d    = (cfg_num_tiles == '0 || cfg_num_ch == '0) ? StFin : StLdWt;
        end
      end
      StLdWt: begin
        wt_ready_c = 1'b1;
        if (wt_valid) begin
          wt_col_we_c = COLS'(1) << col_idx_q;
          if (col_idx_q == CW'(COLS - 1)) begin
            col_idx_d = '0;
            state_d   = StLdIf;
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end
      end
      StLdIf: begin
        if_ready_c = 1'b1;
        if (if_valid) begin
          if_row_we_c = ROWS'(1) << row_idx_q;
          if (row_idx_q == RW'(ROWS - 1)) begin
            row_idx_d  = '0;
            exec_cnt_d = '0;
            state_d    = StExec;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end
      end
      StExec: begin
        // The cycle counter is zero only on the first cycle after entry.
        pe_start_c = (exec_cnt_q == '0);
        pe_acc_c   = (ch_idx_q != '0);
        if (pe_done) begin
          exec_cnt_d = '0;
          if (ch_next < {1'b0, ch_q}) begin
            ch_idx_d = ch_idx_q + 1'b1;
            state_d  = StLdIf;
          end else begin
            ch_idx_d = '0;
            state_d  = StUnldOf;
          end
        end else if (exec_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = StErr;
        end else begin
          exec_cnt_d = exec_cnt_q + 1'b1;
        end
      end
      StUnldOf: begin
        of_valid_c   = 1'b1;
        of_row_sel_c = ROWS'(1) << row_idx_q;
        if (of_ready) begin
          if (row_idx_q == RW'(ROWS - 1)) begin
            row_idx_d  = '0;
            tile_idx_d = tile_idx_q + 1'b1;
            if (tile_next == {1'b0, tiles_q}) state_d = StFin;
            else if (reload_q)                state_d = StLdWt;
            else                              state_d = StLdIf;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end
      end
      StFin: begin
        done_c  = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        err_c = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low combinationally while reset is held.
  assign wt_ready   = ~rst & wt_ready_c;
  assign if_ready   = ~rst & if_ready_c;
  assign pe_start   = ~rst & pe_start_c;
  assign pe_acc     = ~rst & pe_acc_c;
  assign of_valid   = ~rst & of_valid_c;
  assign busy       = ~rst & busy_c;
  assign done       = ~rst & done_c;
  assign err        = ~rst & err_c;
  assign wt_col_we  = rst ? '0 : wt_col_we_c;
  assign if_row_we  = rst ? '0 : if_row_we_c;
  assign of_row_sel = rst ? '0 : of_row_sel_c;

endmodule

// File: tb/tb_dnn_tile_sequencer.sv
// Scoreboard bench for dnn_tile_sequencer: expected stream beats, compute launches and done
// pulses are queued from a job model when a job starts and matched as the DUT emits them.
module tb_dnn_tile_sequencer;

  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [CNT_W-1:0] cfg_num_tiles, cfg_num_ch;
  logic             cfg_wt_reload;
  logic             wt_valid, wt_ready, if_valid, if_ready;
  logic [COLS-1:0]  wt_col_we;
  logic [ROWS-1:0]  if_row_we, of_row_sel;
  logic             pe_start, pe_acc, pe_done, of_valid, of_ready;
  logic             busy, done, err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          stream_mode = 0;  // 0 always ready/valid, 1 if_valid toggles, 2 random
  bit          pe_auto = 1'b1;
  int          pe_lat = 10;
  int          lat, n;

  dnn_tile_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_tiles(cfg_num_tiles), .cfg_num_ch(cfg_num_ch), .cfg_wt_reload(cfg_wt_reload),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_col_we(wt_col_we),
    .if_valid(if_valid), .if_ready(if_ready), .if_row_we(if_row_we),
    .pe_start(pe_start), .pe_acc(pe_acc), .pe_done(pe_done),
    .of_valid(of_valid), .of_ready(of_ready), .of_row_sel(of_row_sel),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_observe(input string tag, input logic [15:0] ev);
    if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, {16'h0, ev}, 32'h0);
    else                   check_eq(tag, {16'h0, ev}, {16'h0, exp_q.pop_front()});
  endtask

  function automatic logic [19:0] all_outs();
    return {wt_ready, wt_col_we, if_ready, if_row_we, pe_start, pe_acc, of_valid, of_row_sel,
            busy, done, err};
  endfunction

  // Event codes: kind in [15:12], payload in the low bits.
  task automatic push_job(input int t, input int c, input bit r);
    logic [3:0] oh;
    if (t == 0 || c == 0) begin
      exp_q.push_back(16'h5000);
      return;
    end
    for (int ti = 0; ti < t; ti++) begin
      if (ti == 0 || r) begin
        for (int k = 0; k < COLS; k++) begin
          oh = 4'b0001 << k;
          exp_q.push_back({4'd1, 8'd0, oh});
        end
      end
      for (int ci = 0; ci < c; ci++) begin
        for (int k = 0; k < ROWS; k++) begin
          oh = 4'b0001 << k;
          exp_q.push_back({4'd2, 8'd0, oh});
        end
        exp_q.push_back({4'd3, 11'd0, (ci != 0)});
      end
      for (int k = 0; k < ROWS; k++) begin
        oh = 4'b0001 << k;
        exp_q.push_back({4'd4, 8'd0, oh});
      end
    end
    exp_q.push_back(16'h5000);
  endtask

  task automatic run_job(input int t, input int c, input bit r, output int l);
    cfg_num_tiles = CNT_W'(t);
    cfg_num_ch    = CNT_W'(c);
    cfg_wt_reload = r;
    push_job(t, c, r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_num_tiles = '1;
    cfg_num_ch    = '1;
    cfg_wt_reload = ~r;
    l = 0;
    do begin
      @(negedge clk);
      l++;
      if (l == 1) check_eq("busy_after_start", busy, 1);
    end while (!done && l < 4000);
    check_eq("job_done_seen", done, 1);
    repeat (3) @(negedge clk);
    check_eq("sb_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Output monitor.
  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_outputs", all_outs(), 0);
    end else begin
      if (wt_valid && wt_ready)  sb_observe("wt_beat", {4'd1, 8'd0, wt_col_we});
      else if (wt_col_we != '0)  check_eq("wt_we_no_beat", wt_col_we, 0);
      if (if_valid && if_ready)  sb_observe("if_beat", {4'd2, 8'd0, if_row_we});
      else if (if_row_we != '0)  check_eq("if_we_no_beat", if_row_we, 0);
      if (pe_start)              sb_observe("pe_start", {4'd3, 11'd0, pe_acc});
      if (of_valid && of_ready)  sb_observe("of_beat", {4'd4, 8'd0, of_row_sel});
      else if (!of_valid && of_row_sel != '0) check_eq("of_sel_idle", of_row_sel, 0);
      if (done)                  sb_observe("done", 16'h5000);
    end
  end

  // Stream sources and sink.
  initial begin
    wt_valid = 1'b0;
    if_valid = 1'b0;
    of_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (stream_mode)
        1: begin wt_valid = 1'b1; of_ready = 1'b1; if_valid = ~if_valid; end
        2: begin
          wt_valid = 1'($urandom_range(1, 0));
          if_valid = 1'($urandom_range(1, 0));
          of_ready = 1'($urandom_range(1, 0));
        end
        default: begin wt_valid = 1'b1; if_valid = 1'b1; of_ready = 1'b1; end
      endcase
    end
  end

  // PE array model: pe_done pulse pe_lat cycles after the launch cycle.
  initial begin
    pe_done = 1'b0;
    forever begin
      @(negedge clk);
      if (pe_start && pe_auto && !rst) begin
        repeat (pe_lat) @(posedge clk);
        #1 pe_done = 1'b1;
        @(posedge clk);
        #1 pe_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_num_tiles = '0; cfg_num_ch = '0; cfg_wt_reload = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("idle_outputs", all_outs(), 0);

    // Single tile, single pass, all streams free-flowing.
    run_job(1, 1, 0, lat);
    // Two tiles, three passes, weights loaded once.
    run_job(2, 3, 0, lat);
    // if_valid stalls every other cycle.
    stream_mode = 1;
    run_job(1, 2, 0, lat);
    // Random stalls on all streams with weight reload.
    stream_mode = 2; pe_lat = 3;
    run_job(2, 2, 1, lat);
    stream_mode = 0; pe_lat = 10;
    run_job(3, 1, 1, lat);

    // Degenerate jobs finish directly.
    run_job(0, 3, 1, lat);
    check_eq("zero_tiles_latency", lat, 1);
    run_job(2, 0, 0, lat);
    check_eq("zero_ch_latency", lat, 1);

    // Timeout: pe_done withheld.
    pe_auto = 1'b0;
    push_job(1, 1, 0);
    repeat (ROWS + 1) void'(exp_q.pop_back());
    cfg_num_tiles = 8'd1; cfg_num_ch = 8'd1; cfg_wt_reload = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!pe_start && n < 200);
    check_eq("to_pe_start_seen", pe_start, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 100);
    check_eq("to_cycles", n, TIMEOUT);
    check_eq("to_err", err, 1);
    check_eq("to_busy", busy, 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("err_ignores_start", {busy, err}, 2'b01);
    check_eq("to_sb_drained", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("err_cleared_by_rst", all_outs(), 0);
    pe_auto = 1'b1;

    // Reset in the middle of ofmap unload.
    push_job(1, 1, 0);
    repeat (3) void'(exp_q.pop_back());
    cfg_num_tiles = 8'd1; cfg_num_ch = 8'd1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
      while (!(of_valid && of_ready && of_row_sel == 4'b0010) && n < 500);
    check_eq("of_beat_reached", of_row_sel, 4'b0010);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_outputs", all_outs(), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_outputs", all_outs(), 0);
    repeat (5) @(negedge clk);
    check_eq("abort_sb_drained", exp_q.size(), 0);
    exp_q.delete();
    run_job(1, 1, 0, lat);

    // Reset wins over start in the same cycle.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("rst_beats_start", busy, 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
